// File: rtl/cpu_pkg.sv
// Shared CPU encodings: branch conditions, ALU op codes and SZCV flag bit positions.
// Used by the execute/writeback stages and any future early-branch logic.
package cpu_pkg;

    typedef enum logic [2:0] {
        COND_BE  = 3'd0,
        COND_BLT = 3'd1,
        COND_BLE = 3'd2,
        COND_BNE = 3'd3,
        COND_B   = 3'd4
    } cond_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;
    localparam logic [3:0] ALU_CMP = 4'b1000;
    localparam logic [3:0] ALU_MOV = 4'b1001;
    localparam logic [3:0] ALU_OUT = 4'b1101;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic s, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_S] = s;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-to-writeback bus: upstream valid/ready with instruction side-band, downstream
// writeback entry with its own valid/ready.
interface alu_result_stage_if #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_s;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_control;
    logic [RD_W-1:0]  rd;
    logic             reg_we;
    logic             set_flags;
    logic             is_branch;
    logic [2:0]       cond;
    logic [WIDTH-1:0] branch_target;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] wb_data;
    logic [RD_W-1:0]  wb_rd;
    logic             wb_we;

    modport master (
        output in_valid, alu_result, alu_s, alu_z, alu_c, alu_v, alu_control,
               rd, reg_we, set_flags, is_branch, cond, branch_target, flush,
               out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_we
    );

    modport slave (
        input  in_valid, alu_result, alu_s, alu_z, alu_c, alu_v, alu_control,
               rd, reg_we, set_flags, is_branch, cond, branch_target, flush,
               out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_we
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution of a 3-bit condition against an SZCV flag word.
// Kept standalone so an early-branch unit can share it.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic s_xor_v;

    assign s_xor_v = flags[FLAG_S] ^ flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = flags[FLAG_Z];
            COND_BLT: taken = s_xor_v;
            COND_BLE: taken = flags[FLAG_Z] | s_xor_v;
            COND_BNE: taken = ~flags[FLAG_Z];
            COND_B:   taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: single-entry result register with valid/ready,
// architectural SZCV flags, branch resolution and the OUT port register.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_result_stage_if.slave bus,
    output logic [3:0]        flags,
    output logic              branch_taken,
    output logic [WIDTH-1:0]  branch_pc,
    output logic [WIDTH-1:0]  port_data,
    output logic              port_strobe
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [RD_W-1:0]  rd_q;
    logic             we_q;
    logic             accept;
    logic             pop;
    logic             cond_taken;
    logic             take_branch;
    logic             out_update;

    assign bus.in_ready  = ~bus.flush & (~valid_q | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = valid_q & bus.out_ready & ~accept;

    assign bus.out_valid = valid_q;
    assign bus.wb_data   = data_q;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_we     = we_q & valid_q;

    // Resolved against the flag register as it stood before this cycle's update.
    branch_cond_eval u_branch_cond_eval (
        .flags (flags),
        .cond  (bus.cond),
        .taken (cond_taken)
    );

    assign take_branch = accept & bus.is_branch & cond_taken;
    assign out_update  = accept & (bus.alu_control == ALU_OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= bus.alu_result;
            rd_q    <= bus.rd;
            we_q    <= bus.reg_we;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (accept && bus.set_flags) begin
            flags <= pack_flags(bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_taken <= 1'b0;
            branch_pc    <= '0;
        end else begin
            branch_taken <= take_branch;
            if (take_branch) begin
                branch_pc <= bus.branch_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_strobe <= 1'b0;
            port_data   <= '0;
        end else begin
            port_strobe <= out_update;
            if (out_update) begin
                port_data <= bus.alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: entries queued on accept, compared on pop,
// with a reference model for flags, branch and OUT-port behaviour.
module tb_alu_result_stage;
    import cpu_pkg::*;

    localparam int WIDTH = 16;
    localparam int RD_W  = 3;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] res;
        logic [3:0]       fl;
        logic [3:0]       ctl;
        logic [RD_W-1:0]  rd;
        logic             we;
        logic             sf;
        logic             br;
        logic [2:0]       cd;
        logic [WIDTH-1:0] tgt;
        logic             flush;
        logic             ordy;
    } stim_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [RD_W-1:0]  rd;
        logic             we;
    } entry_t;

    logic             clk;
    logic             reset;
    logic [3:0]       flags;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_pc;
    logic [WIDTH-1:0] port_data;
    logic             port_strobe;

    alu_result_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .flags        (flags),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .port_data    (port_data),
        .port_strobe  (port_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    entry_t           sb_q[$];
    logic             m_valid;
    logic [3:0]       m_flags;
    logic [WIDTH-1:0] m_bpc;
    logic [WIDTH-1:0] m_pdata;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Flags layout {S,Z,C,V}
    function automatic logic model_taken(input logic [3:0] f, input logic [2:0] cd);
        logic s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (cd)
            3'd0:    return z;
            3'd1:    return s ^ v;
            3'd2:    return z | (s ^ v);
            3'd3:    return !z;
            3'd4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stim_t idle(input logic ordy);
        stim_t s;
        s      = '0;
        s.ordy = ordy;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.in_valid      = s.v;
        bus.alu_result    = s.res;
        bus.alu_s         = s.fl[3];
        bus.alu_z         = s.fl[2];
        bus.alu_c         = s.fl[1];
        bus.alu_v         = s.fl[0];
        bus.alu_control   = s.ctl;
        bus.rd            = s.rd;
        bus.reg_we        = s.we;
        bus.set_flags     = s.sf;
        bus.is_branch     = s.br;
        bus.cond          = s.cd;
        bus.branch_target = s.tgt;
        bus.flush         = s.flush;
        bus.out_ready     = s.ordy;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic drive(input stim_t s);
        logic   exp_ready, acc, exp_bt, exp_ps;
        entry_t e;
        apply(s);
        #1;
        exp_ready = !s.flush && (!m_valid || s.ordy);
        check_val("in_ready", bus.in_ready, exp_ready);
        acc = s.v && exp_ready;
        if (m_valid && sb_q.size() > 0) begin
            check_val("wb_data_hold", bus.wb_data, sb_q[0].data);
        end
        if (m_valid && (s.ordy || s.flush)) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                if (s.ordy) begin
                    check_val("wb_rd", bus.wb_rd, e.rd);
                    check_val("wb_we", bus.wb_we, e.we);
                end
            end
        end
        if (acc) begin
            e.data = s.res;
            e.rd   = s.rd;
            e.we   = s.we;
            sb_q.push_back(e);
        end
        exp_bt = acc && s.br && model_taken(m_flags, s.cd);
        if (exp_bt) m_bpc = s.tgt;
        if (acc && s.sf) m_flags = s.fl;
        exp_ps = acc && (s.ctl == ALU_OUT);
        if (exp_ps) m_pdata = s.res;
        if (s.flush)                m_valid = 1'b0;
        else if (acc)               m_valid = 1'b1;
        else if (m_valid && s.ordy) m_valid = 1'b0;

        @(posedge clk);
        #1;
        check_val("out_valid", bus.out_valid, m_valid);
        check_val("flags", flags, m_flags);
        check_val("branch_taken", branch_taken, exp_bt);
        check_val("branch_pc", branch_pc, m_bpc);
        check_val("port_strobe", port_strobe, exp_ps);
        check_val("port_data", port_data, m_pdata);
        @(negedge clk);
    endtask

    function automatic stim_t op(input logic [WIDTH-1:0] res, input logic [3:0] ctl,
                                 input logic [RD_W-1:0] rd, input logic ordy);
        stim_t s;
        s      = '0;
        s.v    = 1'b1;
        s.res  = res;
        s.ctl  = ctl;
        s.rd   = rd;
        s.we   = 1'b1;
        s.ordy = ordy;
        return s;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_flags = 4'b0000;
        m_bpc   = '0;
        m_pdata = '0;
        sb_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, bus.out_valid, 0);
        check_val({tag, "_wb_data"}, bus.wb_data, 0);
        check_val({tag, "_wb_rd"}, bus.wb_rd, 0);
        check_val({tag, "_wb_we"}, bus.wb_we, 0);
        check_val({tag, "_flags"}, flags, 0);
        check_val({tag, "_branch_taken"}, branch_taken, 0);
        check_val({tag, "_branch_pc"}, branch_pc, 0);
        check_val({tag, "_port_data"}, port_data, 0);
        check_val({tag, "_port_strobe"}, port_strobe, 0);
    endtask

    initial begin
        stim_t s;
        model_reset();
        apply(idle(1'b0));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Backpressure, then replace-on-pop with no bubble
        drive(op(16'h1234, ALU_ADD, 3'd5, 1'b0));
        repeat (3) drive(op(16'h5555, ALU_ADD, 3'd2, 1'b0));
        drive(op(16'h00FF, ALU_MOV, 3'd1, 1'b1));
        check_val("bp_wb_data_next", bus.wb_data, 16'h00FF);
        drive(idle(1'b1));

        // CMP: S=1 V=0, then BLT taken, BE not taken
        s = op(16'hFFFE, ALU_CMP, 3'd0, 1'b1); s.we = 1'b0; s.sf = 1'b1; s.fl = 4'b1000;
        drive(s);
        s = op(16'h0000, ALU_ADD, 3'd0, 1'b1); s.we = 1'b0; s.br = 1'b1;
        s.cd = COND_BLT; s.tgt = 16'h0040;
        drive(s);
        check_val("blt_pc", branch_pc, 16'h0040);
        s.cd = COND_BE; s.tgt = 16'h0080;
        drive(s);
        drive(idle(1'b1));

        // Z=1, then branch BE with flag update to Z=0 in the same accept
        s = op(16'h0000, ALU_CMP, 3'd0, 1'b1); s.we = 1'b0; s.sf = 1'b1; s.fl = 4'b0100;
        drive(s);
        s = op(16'h0001, ALU_SUB, 3'd3, 1'b1); s.sf = 1'b1; s.fl = 4'b0010;
        s.br = 1'b1; s.cd = COND_BE; s.tgt = 16'h0123;
        drive(s);
        check_val("same_cycle_z", flags[FLAG_Z], 0);
        drive(idle(1'b1));

        // Flush with a valid entry held and a flag/OUT instruction offered
        drive(op(16'hAAAA, ALU_ADD, 3'd6, 1'b0));
        s = op(16'h7777, ALU_OUT, 3'd4, 1'b0); s.sf = 1'b1; s.fl = 4'b1111;
        s.br = 1'b1; s.cd = COND_B; s.tgt = 16'h0999; s.flush = 1'b1;
        drive(s);
        drive(idle(1'b1));

        // Back-to-back OUT
        drive(op(16'hBEEF, ALU_OUT, 3'd0, 1'b1));
        check_val("out1_data", port_data, 16'hBEEF);
        drive(op(16'h0001, ALU_OUT, 3'd0, 1'b1));
        check_val("out2_data", port_data, 16'h0001);
        drive(idle(1'b1));

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            s       = '0;
            s.v     = 1'($urandom_range(0, 3) != 0);
            s.res   = 16'($urandom);
            s.fl    = 4'($urandom);
            s.ctl   = ($urandom_range(0, 3) == 0) ? ALU_OUT : 4'($urandom_range(0, 9));
            s.rd    = 3'($urandom);
            s.we    = 1'($urandom);
            s.sf    = 1'($urandom);
            s.br    = 1'($urandom);
            s.cd    = 3'($urandom);
            s.tgt   = 16'($urandom);
            s.flush = 1'($urandom_range(0, 7) == 0);
            s.ordy  = 1'($urandom_range(0, 2) != 0);
            drive(s);
        end

        // Reset mid-entry with non-zero state everywhere
        s = op(16'hC0DE, ALU_OUT, 3'd7, 1'b0); s.sf = 1'b1; s.fl = 4'b1111;
        s.br = 1'b1; s.cd = COND_B; s.tgt = 16'h0F0F;
        drive(s);
        apply(op(16'h1111, ALU_ADD, 3'd1, 1'b0));
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("post_reset_in_ready", bus.in_ready, 1);
        @(negedge clk);
        drive(op(16'h4242, ALU_ADD, 3'd2, 1'b1));
        repeat (3) drive(idle(1'b1));
        check_val("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Registers the ALU result, destination and write enable into a single-entry pipeline register with a valid/ready handshake.
- Holds the architectural SZCV flag register and resolves conditional branches against it.
- Latches OUT-instruction data into an external output register.

Parameters:
- WIDTH, 16, datapath width of result, branch target and output port.
- RD_W, 3, register-file address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid ALU result.
- in_ready  out  1  stage can accept this cycle.
- alu_result  in  WIDTH  ALU result.
- alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs.
- alu_control  in  4  ALU op code; 4'b1101 = OUT.
- rd  in  RD_W  destination register.
- reg_we  in  1  instruction writes rd.
- set_flags  in  1  instruction updates SZCV.
- is_branch  in  1  instruction is a branch.
- cond  in  3  branch condition: 0 BE, 1 BLT, 2 BLE, 3 BNE, 4 B (always); 5-7 never taken.
- branch_target  in  WIDTH  target PC.
- flush  in  1  kill the accepted entry and block new acceptance this cycle.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes the entry.
- wb_data  out  WIDTH  registered result.
- wb_rd  out  RD_W  registered destination.
- wb_we  out  1  registered write enable, qualified by out_valid.
- flags  out  4  architectural {S,Z,C,V}.
- branch_taken  out  1  one-cycle pulse.
- branch_pc  out  WIDTH  registered target, valid when branch_taken is high.
- port_data  out  WIDTH  OUT register.
- port_strobe  out  1  one-cycle pulse on an OUT update.

Behaviour:
- Reset: out_valid=0, wb_data=0, wb_rd=0, wb_we=0, flags=4'b0000, branch_taken=0, branch_pc=0, port_data=0, port_strobe=0. Reset applies asynchronously at any point, including mid-handshake; the in-flight entry is dropped.
- in_ready = !flush & (!out_valid | out_ready). Combinational; must not depend on in_valid.
- Accept = in_valid & in_ready. On accept: load wb_data, wb_rd and wb_we (reg_we), and set out_valid=1. Latency is one cycle from accept to out_valid.
- Pop = out_valid & out_ready & !accept sets out_valid=0. Simultaneous pop and accept replaces the entry; there is no bubble.
- Without out_ready the entry holds; wb_* stay stable.
- flush=1: out_valid<=0 next cycle, no accept that cycle, flags and port unchanged; branch_taken<=0.
- Flags: on accept with set_flags=1, flags <= {alu_s,alu_z,alu_c,alu_v}; otherwise they hold. set_flags=0 never changes flags.
- Branch: evaluated on accept with is_branch=1, using the flags value before any update in the same cycle. Conditions (S,Z,V from the flag register):
  - BE: Z.
  - BLT: S^V.
  - BLE: Z | (S^V).
  - BNE: !Z.
  - B: 1.
  - cond 5-7: 0.
- If taken: branch_taken<=1 for exactly one cycle and branch_pc<=branch_target. branch_pc holds otherwise. is_branch with set_flags both high is legal: the branch uses the old flags, and the flags then update.
- OUT: on accept with alu_control==4'b1101, port_data<=alu_result and port_strobe<=1 for one cycle. Back-to-back OUT accepts give back-to-back strobes.
- branch_taken and port_strobe are 0 in every cycle that has no qualifying accept.
- Width: all data paths are WIDTH bits wide with no extension or truncation.

Decomposition:
- Shared package (cpu_pkg): condition encodings COND_BE/BLT/BLE/BNE/B; ALU op constants including ALU_OUT=4'b1101; flag bit indices FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, branch_cond_eval: combinational, takes (flags, cond) and returns taken. It is reusable by a future early-branch unit.

Test Plan:
- Reset mid-entry: out_valid=1, then assert reset -> all outputs 0 immediately; in_ready=1 after release.
- Backpressure: accept result 16'h1234 rd=5 with out_ready=0 for 3 cycles -> wb_data stays 16'h1234, in_ready=0; on out_ready=1 a simultaneous new accept of 16'h00FF gives out_valid=1, wb_data=16'h00FF next cycle.
- Flags and branch: CMP sets flags S=1 V=0, then BLT target 16'h0040 -> branch_taken pulses one cycle, branch_pc=16'h0040; BE with Z=0 -> no pulse.
- Same-cycle update: flags Z=1, then an instruction with set_flags=1 (Z=0) and is_branch=1 with cond BE -> taken, and flags Z=0 afterwards.
- Flush: flush=1 with in_valid=1 -> in_ready=0, out_valid=0 next cycle, flags unchanged, no strobes.
- OUT: two consecutive accepts with alu_control=1101 and data 16'hBEEF, 16'h0001 -> port_strobe high for two cycles, port_data ends at 16'h0001.
